// File: rtl/als_pkg.sv
// Shared widths and field positions for the ambient-light level meter.
package als_pkg;

   localparam int unsigned FRAME_W    = 16;
   localparam int unsigned SAMPLE_MSB = 11;
   localparam int unsigned SAMPLE_LSB = 4;
   localparam int unsigned LEVEL_W    = 8;
   localparam int unsigned SUM_W      = 10;
   localparam int unsigned AVG_DEPTH  = 4;
   localparam int unsigned LED_W      = 16;
   localparam int unsigned LED_IDX_W  = 4;

endpackage

// File: rtl/als_avg4.sv
// Four-sample moving average: history, running sum and the registered level output.
module als_avg4
   import als_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               accept,
   input  logic [LEVEL_W-1:0] sample,
   output logic [LEVEL_W-1:0] level,
   output logic               level_valid
);

   logic [LEVEL_W-1:0] hist [AVG_DEPTH];
   logic [SUM_W-1:0]   sum;
   logic               upd;

   // Sum never underflows: the discarded sample is always part of the current sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(AVG_DEPTH); i++) hist[i] <= '0;
         sum         <= '0;
         upd         <= 1'b0;
         level       <= '0;
         level_valid <= 1'b0;
      end else begin
         upd         <= accept;
         level_valid <= upd;
         if (accept) begin
            sum     <= sum + SUM_W'(sample) - SUM_W'(hist[AVG_DEPTH-1]);
            hist[0] <= sample;
            for (int i = 1; i < int'(AVG_DEPTH); i++) hist[i] <= hist[i-1];
         end
         if (upd) level <= sum[SUM_W-1 -: LEVEL_W];
      end
   end

endmodule

// File: rtl/als_level_meter.sv
// Ambient-light level meter: frame edge detect, averaging, peak hold with decay,
// staleness timeout and bar-graph LED drive.
module als_level_meter
   import als_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES    = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               d_ready,
   input  logic [FRAME_W-1:0] d,
   output logic [LEVEL_W-1:0] level,
   output logic               level_valid,
   output logic [LEVEL_W-1:0] peak,
   output logic               stale,
   output logic [LED_W-1:0]   led
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   logic                d_ready_q;
   logic                accept_c;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [TO_W-1:0]     to_cnt;
   logic [TO_W-1:0]     to_next_c;
   logic                stale_next_c;
   logic [LED_W-1:0]    bar_c;
   logic                unused_bits_c;

   assign accept_c      = d_ready & ~d_ready_q;
   assign unused_bits_c = ^{d[FRAME_W-1:SAMPLE_MSB+1], d[SAMPLE_LSB-1:0]};

   als_avg4 u_avg4 (
      .clk         (clk),
      .rst         (rst),
      .accept      (accept_c),
      .sample      (d[SAMPLE_MSB:SAMPLE_LSB]),
      .level       (level),
      .level_valid (level_valid)
   );

   // Timeout lookahead lets the LED blanking line up with the stale flag.
   always_comb begin
      to_next_c    = to_cnt;
      stale_next_c = 1'b0;
      bar_c        = '0;
      if (accept_c)               to_next_c = '0;
      else if (to_cnt != TO_LAST) to_next_c = to_cnt + TO_W'(1);
      stale_next_c = (to_next_c == TO_LAST);
      for (int i = 0; i < int'(LED_W); i++)
         bar_c[i] = (LED_IDX_W'(i) < level[LEVEL_W-1 -: LED_IDX_W]);
      if (peak != '0) bar_c[peak[LEVEL_W-1 -: LED_IDX_W]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_ready_q <= 1'b0;
         hold_cnt  <= '0;
         to_cnt    <= '0;
         peak      <= '0;
         stale     <= 1'b0;
         led       <= '0;
      end else begin
         d_ready_q <= d_ready;
         to_cnt    <= to_next_c;
         stale     <= stale_next_c;
         led       <= stale_next_c ? '0 : bar_c;
         if (level > peak) begin
            peak     <= level;
            hold_cnt <= '0;
         end else if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            if (peak != '0) peak <= peak - LEVEL_W'(1);
         end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_als_level_meter.sv
// Scoreboard bench for als_level_meter with short hold and timeout periods.
module tb_als_level_meter;

   logic        clk = 1'b0;
   logic        rst;
   logic        d_ready;
   logic [15:0] d;
   logic [7:0]  level;
   logic        level_valid;
   logic [7:0]  peak;
   logic        stale;
   logic [15:0] led;

   int total = 0;
   int bad   = 0;
   int vld_cnt = 0;

   logic [7:0] exp_q [$];
   logic [7:0] mh [4];

   als_level_meter #(.HOLD_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .d_ready     (d_ready),
      .d           (d),
      .level       (level),
      .level_valid (level_valid),
      .peak        (peak),
      .stale       (stale),
      .led         (led)
   );

   always #5 clk = ~clk;

   // Scoreboard: every level_valid pulse must match the next expected average.
   always @(negedge clk) begin
      if (level_valid === 1'b1) begin
         logic [7:0] e;
         vld_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: level=%h, required no level_valid", level);
         end else begin
            e = exp_q.pop_front();
            if (level !== e) begin
               bad++;
               $display("FAIL level_update: level=%h required=%h", level, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mh[i] = 8'h00;
   endtask

   task automatic model_frame(input logic [15:0] f);
      logic [9:0] s;
      for (int i = 3; i > 0; i--) mh[i] = mh[i-1];
      mh[0] = f[11:4];
      s = 10'(mh[0]) + 10'(mh[1]) + 10'(mh[2]) + 10'(mh[3]);
      exp_q.push_back(s[9:2]);
   endtask

   task automatic send(input logic [15:0] f, input int hold, input int gap);
      d = f;
      d_ready = 1'b1;
      model_frame(f);
      tick(hold);
      d_ready = 1'b0;
      tick(gap);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      d_ready = 1'b0;
      tick(2);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d_ready = 1'b0;
      d = 16'h0;
      tick(3);
      total += 5;
      if (level !== 8'h00)     begin bad++; $display("FAIL reset_level: got=%h required=00", level); end
      if (peak !== 8'h00)      begin bad++; $display("FAIL reset_peak: got=%h required=00", peak); end
      if (level_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b required=0", level_valid); end
      if (stale !== 1'b0)      begin bad++; $display("FAIL reset_stale: got=%b required=0", stale); end
      if (led !== 16'h0000)    begin bad++; $display("FAIL reset_led: got=%h required=0000", led); end
      rst = 1'b0;
      model_reset();
      tick(1);
   endtask

   task automatic test_ramp();
      send(16'h0FF0, 1, 9);
      total++;
      if (led !== 16'h000F) begin bad++; $display("FAIL ramp_led_first: got=%h required=000F", led); end
      send(16'h0FF0, 1, 9);
      send(16'h0FF0, 1, 9);
      send(16'h0FF0, 1, 4);
      total += 3;
      if (level !== 8'hFF)  begin bad++; $display("FAIL ramp_level: got=%h required=FF", level); end
      if (peak !== 8'hFF)   begin bad++; $display("FAIL ramp_peak: got=%h required=FF", peak); end
      if (led !== 16'hFFFF) begin bad++; $display("FAIL ramp_led_full: got=%h required=FFFF", led); end
      tick(5);
   endtask

   task automatic test_stale();
      send(16'h0FF0, 1, 0);
      tick(62);
      total++;
      if (stale !== 1'b0) begin bad++; $display("FAIL stale_early: got=%b required=0", stale); end
      tick(1);
      total += 3;
      if (stale !== 1'b1)   begin bad++; $display("FAIL stale_set: got=%b required=1", stale); end
      if (led !== 16'h0000) begin bad++; $display("FAIL stale_led: got=%h required=0000", led); end
      if (level !== 8'hFF)  begin bad++; $display("FAIL stale_level_kept: got=%h required=FF", level); end
      send(16'h0FF0, 1, 0);
      total += 2;
      if (stale !== 1'b0)   begin bad++; $display("FAIL stale_clear: got=%b required=0", stale); end
      if (led !== 16'hFFFF) begin bad++; $display("FAIL stale_led_restore: got=%h required=FFFF", led); end
      tick(9);
   endtask

   task automatic test_decay();
      logic [7:0] p0;
      logic [7:0] e;
      for (int k = 0; k < 4; k++) send(16'h0000, 1, 9);
      total++;
      if (level !== 8'h00) begin bad++; $display("FAIL decay_level: got=%h required=00", level); end
      p0 = peak;
      for (int k = 1; k <= 2; k++) begin
         tick(8);
         e = (p0 > 8'(k)) ? p0 - 8'(k) : 8'h00;
         total++;
         if (peak !== e) begin bad++; $display("FAIL decay_step%0d: peak=%h required=%h", k, peak, e); end
      end
   endtask

   task automatic test_hold_high();
      int c0;
      do_reset();
      c0 = vld_cnt;
      send(16'h0FF0, 20, 10);
      total += 2;
      if (vld_cnt - c0 !== 1) begin bad++; $display("FAIL held_ready_pulses: got=%0d required=1", vld_cnt - c0); end
      if (level !== 8'h3F)    begin bad++; $display("FAIL held_ready_level: got=%h required=3F", level); end
   endtask

   task automatic test_masked();
      do_reset();
      send(16'hF00F, 1, 9);
      total += 3;
      if (level !== 8'h00)  begin bad++; $display("FAIL masked_level: got=%h required=00", level); end
      if (peak !== 8'h00)   begin bad++; $display("FAIL masked_peak: got=%h required=00", peak); end
      if (led !== 16'h0000) begin bad++; $display("FAIL masked_led: got=%h required=0000", led); end
   endtask

   task automatic test_reset_collision();
      int c0;
      c0 = vld_cnt;
      rst = 1'b1;
      d = 16'h0FF0;
      d_ready = 1'b1;
      tick(1);
      rst = 1'b0;
      d_ready = 1'b0;
      model_reset();
      tick(4);
      total++;
      if (vld_cnt - c0 !== 0) begin bad++; $display("FAIL collision_lost: pulses=%0d required=0", vld_cnt - c0); end
      send(16'h0FF0, 1, 9);
      total++;
      if (level !== 8'h3F) begin bad++; $display("FAIL collision_level: got=%h required=3F", level); end
   endtask

   task automatic test_release_high();
      int c0;
      c0 = vld_cnt;
      rst = 1'b1;
      d = 16'h0FF0;
      d_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      model_reset();
      model_frame(16'h0FF0);
      tick(5);
      d_ready = 1'b0;
      tick(5);
      total += 2;
      if (vld_cnt - c0 !== 1) begin bad++; $display("FAIL release_pulses: got=%0d required=1", vld_cnt - c0); end
      if (level !== 8'h3F)    begin bad++; $display("FAIL release_level: got=%h required=3F", level); end
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = vld_cnt;
      send(16'h0400, 1, 1);
      send(16'h0800, 1, 1);
      send(16'h0C00, 1, 6);
      total++;
      if (vld_cnt - c0 !== 3) begin bad++; $display("FAIL b2b_pulses: got=%0d required=3", vld_cnt - c0); end
   endtask

   initial begin
      rst = 1'b1;
      d_ready = 1'b0;
      d = 16'h0;
      model_reset();
      test_reset();
      test_ramp();
      test_stale();
      test_decay();
      test_hold_high();
      test_masked();
      test_reset_collision();
      test_release_high();
      test_back_to_back();
      tick(4);
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL missing_updates: pending=%0d required=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/als_level_meter.md
ALS_LEVEL_METER -- requirements
Module: als_level_meter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, clock cycles between peak-decay steps.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, clock cycles without an accepted frame before stale asserts.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port d_ready  input  1  SPI frame-complete level from the upstream SPI reader, synchronous to clk.
REQ-006 SHALL have port d  input  16  SPI frame; stable while d_ready is high.
REQ-007 SHALL have port level  output  8  averaged light level.
REQ-008 SHALL have port level_valid  output  1  one-cycle pulse when level updates.
REQ-009 SHALL have port peak  output  8  peak-hold level.
REQ-010 SHALL have port stale  output  1  no frame within TIMEOUT_CYCLES.
REQ-011 SHALL have port led  output  16  bar-graph drive.

Function
REQ-012 Frame acceptance SHALL occur only at edge n where d_ready=1 and registered d_ready_q=0; a held-high d_ready SHALL yield exactly one acceptance.
REQ-013 Sample SHALL be d[11:4] (8 bits); all other bits of d SHALL be ignored.
REQ-014 A 4-entry sample history plus 10-bit running sum SHALL update at edge n: sum = sum + new - oldest, oldest discarded; no overflow possible.
REQ-015 At edge n+1, level SHALL load sum[9:2] and level_valid SHALL go high; at n+2 level_valid SHALL return low unless a new acceptance occurred at n+1.
REQ-016 Back-to-back acceptances (minimum spacing 2 cycles via REQ-012) SHALL each produce their own level_valid pulse; no frame dropped.
REQ-017 History starts at zero, so first three levels after reset SHALL ramp (sum/4 with zero fill); no fill-count logic.
REQ-018 Peak: when level (registered) > peak, peak SHALL load level next cycle and hold counter SHALL clear.
REQ-019 Otherwise hold counter SHALL increment; on reaching HOLD_CYCLES-1 it SHALL clear and peak SHALL decrement by 1, saturating at 0.
REQ-020 Simultaneous level>peak and decay tick: load SHALL win, counter SHALL clear.
REQ-021 Timeout counter SHALL clear on each acceptance, else increment, saturating at TIMEOUT_CYCLES-1; stale SHALL be high while counter = TIMEOUT_CYCLES-1; cleared the cycle after the next acceptance.
REQ-022 led SHALL be registered, updating one cycle after level/peak: led[i]=1 for i < level[7:4]; additionally led[peak[7:4]]=1 when peak != 0.
REQ-023 While stale=1, led SHALL be 16'h0000; level and peak retain their values.

Reset
REQ-024 With rst=1 at a clock edge, level, peak, level_valid, stale, led, sum, history, d_ready_q, and both counters SHALL be 0 next cycle.
REQ-025 Reset SHALL override a simultaneous acceptance; that frame SHALL be lost.
REQ-026 After reset release, a d_ready already high SHALL be accepted once at the first edge (d_ready_q=0).

Structure
REQ-027 Package als_pkg SHALL hold SAMPLE_MSB=11, SAMPLE_LSB=4, LEVEL_W=8, SUM_W=10, AVG_DEPTH=4.
REQ-028 Sub-module als_avg4 SHALL contain the history, running sum and level/level_valid registers; peak, timeout and led logic stay in als_level_meter.

Verification (HOLD_CYCLES=8, TIMEOUT_CYCLES=64 unless stated)
REQ-029 Reset, four frames d=16'h0FF0 spaced 10 cycles -> level 0x3F,0x7F,0xBF,0xFF; led 16'h000F after first, 16'hFFFF after fourth; peak 0xFF.
REQ-030 Single frame 16'h0FF0 with d_ready held high 20 cycles -> exactly one level_valid pulse, level 0x3F.
REQ-031 After REQ-029, four frames 16'h0000 -> level 0xBF,0x7F,0x3F,0x00; peak holds 0xFF, then decrements by 1 every 8 cycles once level stops exceeding it.
REQ-032 Frame d=16'hF00F after reset -> level 0x00, peak 0x00, led 16'h0000.
REQ-033 rst asserted on the acceptance edge of frame 16'h0FF0, next frame 16'h0FF0 -> level 0x3F (not 0x7F).
REQ-034 No frames for 64 cycles after REQ-029 -> stale=1, led 16'h0000; next frame clears stale and restores led.
